// File: rtl/mux4_to_1_tdm.sv
// Four-channel TDM transmitter: buffers one word per channel and sends pending
// words round-robin, one per clock, tagged with their channel number on {s1,s0}.
module mux4_to_1_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [3:0]       wr,
  input  logic             clr_ovf,
  output logic [3:0]       busy,
  output logic [WIDTH-1:0] out,
  output logic             s1,
  output logic             s0,
  output logic             out_valid,
  output logic [3:0]       overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hold [4];
  logic [WIDTH-1:0] in_arr [4];
  logic [1:0]       rr_ptr;
  logic [1:0]       gnt_idx;
  logic             gnt_found;
  logic             gnt_en;
  logic [3:0]       gnt_oh;
  logic [3:0]       capture;
  logic [3:0]       busy_next;
  logic [3:0]       overflow_next;

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;

  // Search starts just past the last granted channel; k=4 wraps back to rr_ptr itself.
  always_comb begin
    logic [1:0] cand;
    gnt_idx   = rr_ptr;
    gnt_found = 1'b0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!gnt_found && busy[cand]) begin
        gnt_idx   = cand;
        gnt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|busy_next)  state_next = SEND;
      SEND:    if (!(|busy_next)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_en = 1'b0;
    gnt_oh = 4'b0000;
    if (state == SEND && gnt_found) begin
      gnt_en = 1'b1;
      gnt_oh = 4'b0001 << gnt_idx;
    end
  end

  // A busy channel may only be rewritten on the cycle its old word leaves.
  always_comb begin
    capture       = wr & (~busy | gnt_oh);
    busy_next     = capture | (busy & ~gnt_oh);
    overflow_next = (overflow & {4{~clr_ovf}}) | (wr & busy & ~gnt_oh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 4'b0000;
      overflow <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
      end
    end else begin
      busy     <= busy_next;
      overflow <= overflow_next;
      for (int i = 0; i < 4; i++) begin
        if (capture[i]) begin
          hold[i] <= in_arr[i];
        end
      end
    end
  end

  // rr_ptr resets to 3 so that channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      out_valid <= 1'b0;
      rr_ptr    <= 2'd3;
    end else begin
      out_valid <= gnt_en;
      if (gnt_en) begin
        out    <= hold[gnt_idx];
        s1     <= gnt_idx[1];
        s0     <= gnt_idx[0];
        rr_ptr <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux4_to_1_tdm.sv
// Self-checking bench for mux4_to_1_tdm: scenario tasks with inline checks plus a
// scoreboard that pairs every out_valid word with the next expected {channel, data}.
module tb_mux4_to_1_tdm;

  localparam int W = 8;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in0, in1, in2, in3;
  logic [3:0]   wr;
  logic         clr_ovf;
  logic [3:0]   busy;
  logic [W-1:0] out;
  logic         s1, s0, out_valid;
  logic [3:0]   overflow;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  mux4_to_1_tdm #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .wr(wr), .clr_ovf(clr_ovf),
    .busy(busy), .out(out), .s1(s1), .s0(s0),
    .out_valid(out_valid), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard: every transmitted word must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb_unexpected: sel=%0d data=%h sent, required no word", {s1, s0}, out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({s1, s0} !== e.sel || out !== e.data) begin
          fails++;
          $display("[TB] FAIL sb_word: sel=%0d data=%h, required sel=%0d data=%h",
                   {s1, s0}, out, e.sel, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [W-1:0] data);
    exp_t e;
    e.sel  = sel;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr      = 4'b0000;
    clr_ovf = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wr = 4'b0000; clr_ovf = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out, s1, s0, out_valid, busy, overflow} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_async: out=%h sel=%0d v=%b busy=%b ovf=%b, required all 0",
               out, {s1, s0}, out_valid, busy, overflow);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 4'b0000 || overflow !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_idle: v=%b busy=%b ovf=%b, required 0/0000/0000", out_valid, busy, overflow);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    in2 = 8'hA5; wr = 4'b0100;
    push(2'd2, 8'hA5);
    tick();
    wr = 4'b0000;
    tests++;
    if (busy !== 4'b0100 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_e0: busy=%b v=%b, required 0100/0", busy, out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || {s1, s0} !== 2'd2 || out !== 8'hA5 || busy !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL single_e1: v=%b sel=%0d out=%h busy=%b, required 1/2/a5/0000",
               out_valid, {s1, s0}, out, busy);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || {s1, s0} !== 2'd2 || out !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL single_hold: v=%b sel=%0d out=%h, required 0/2/a5", out_valid, {s1, s0}, out);
    end
  endtask

  task automatic test_all_four();
    logic [W-1:0] d [4];
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = W'($urandom_range(0, 255));
    in0 = d[0]; in1 = d[1]; in2 = d[2]; in3 = d[3];
    wr = 4'b1111;
    for (int i = 0; i < 4; i++) push(2'(i), d[i]);
    tick();
    wr = 4'b0000;
    tests++;
    if (busy !== 4'b1111) begin
      fails++;
      $display("[TB] FAIL all4_busy: busy=%b, required 1111", busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || {s1, s0} !== 2'(i)) begin
        fails++;
        $display("[TB] FAIL all4_grant%0d: v=%b sel=%0d, required 1/%0d", i, out_valid, {s1, s0}, i);
      end
    end
    tests++;
    if (busy !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL all4_drained: busy=%b, required 0000", busy);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL all4_end: v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    in3 = 8'h3C; wr = 4'b1000;
    push(2'd3, 8'h3C);
    tick();
    wr = 4'b0000;
    tick();
    in0 = 8'h0F; in3 = 8'hF0; wr = 4'b1001;
    push(2'd0, 8'h0F);
    push(2'd3, 8'hF0);
    tick();
    wr = 4'b0000;
    tick();
    tests++;
    if ({s1, s0} !== 2'd0 || out_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rr_wrap_first: sel=%0d v=%b, required 0/1", {s1, s0}, out_valid);
    end
    tick();
    tests++;
    if ({s1, s0} !== 2'd3 || out_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rr_wrap_second: sel=%0d v=%b, required 3/1", {s1, s0}, out_valid);
    end
    // Pointer now parked on channel 1 so channel 3 outranks channel 0.
    in1 = 8'h5A; wr = 4'b0010;
    push(2'd1, 8'h5A);
    tick();
    wr = 4'b0000;
    tick();
    in0 = 8'h77; in3 = 8'h88; wr = 4'b1001;
    push(2'd3, 8'h88);
    push(2'd0, 8'h77);
    tick();
    wr = 4'b0000;
    tick();
    tests++;
    if ({s1, s0} !== 2'd3) begin
      fails++;
      $display("[TB] FAIL rr_from1_first: sel=%0d, required 3", {s1, s0});
    end
    tick();
    tests++;
    if ({s1, s0} !== 2'd0) begin
      fails++;
      $display("[TB] FAIL rr_from1_second: sel=%0d, required 0", {s1, s0});
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL rr_drain: %0d words outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    in0 = 8'hC0; in1 = 8'hB1; wr = 4'b0011;
    push(2'd0, 8'hC0);
    push(2'd1, 8'hB1);
    tick();
    in1 = 8'hB2; wr = 4'b0010;
    tick();
    wr = 4'b0000;
    tests++;
    if (overflow !== 4'b0010 || busy !== 4'b0010 || {s1, s0} !== 2'd0) begin
      fails++;
      $display("[TB] FAIL ovf_set: ovf=%b busy=%b sel=%0d, required 0010/0010/0", overflow, busy, {s1, s0});
    end
    tick();
    tests++;
    if ({s1, s0} !== 2'd1 || out !== 8'hB1 || overflow !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL ovf_first_kept: sel=%0d out=%h ovf=%b, required 1/b1/0010", {s1, s0}, out, overflow);
    end
    tick();
    tick();
    tests++;
    if (overflow !== 4'b0010 || busy !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL ovf_sticky: ovf=%b busy=%b, required 0010/0000", overflow, busy);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tests++;
    if (overflow !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL ovf_clear: ovf=%b, required 0000", overflow);
    end
    in0 = 8'hD0; in1 = 8'hD1; wr = 4'b0011;
    push(2'd0, 8'hD0);
    push(2'd1, 8'hD1);
    tick();
    in1 = 8'hEE; wr = 4'b0010; clr_ovf = 1'b1;
    tick();
    wr = 4'b0000; clr_ovf = 1'b0;
    tests++;
    if (overflow !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL ovf_set_beats_clr: ovf=%b, required 0010", overflow);
    end
    tick();
    tests++;
    if ({s1, s0} !== 2'd1 || out !== 8'hD1) begin
      fails++;
      $display("[TB] FAIL ovf_dropped_word: sel=%0d out=%h, required 1/d1", {s1, s0}, out);
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL ovf_drain: %0d words outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_rewrite_during_grant();
    do_reset();
    in0 = 8'h1A; wr = 4'b0001;
    push(2'd0, 8'h1A);
    tick();
    in0 = 8'h2B;
    push(2'd0, 8'h2B);
    tick();
    wr = 4'b0000;
    tests++;
    if (out !== 8'h1A || busy !== 4'b0001 || overflow !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL rewrite_old: out=%h busy=%b ovf=%b, required 1a/0001/0000", out, busy, overflow);
    end
    tick();
    tests++;
    if (out !== 8'h2B || out_valid !== 1'b1 || busy !== 4'b0000 || overflow !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL rewrite_new: out=%h v=%b busy=%b ovf=%b, required 2b/1/0000/0000",
               out, out_valid, busy, overflow);
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL rewrite_drain: %0d words outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in2 = 8'h99; wr = 4'b0100;
    push(2'd2, 8'h99);
    tick();
    in1 = 8'h42; in3 = 8'h43; wr = 4'b1010;
    tick();
    wr = 4'b0000;
    tests++;
    if (busy !== 4'b1010 || out_valid !== 1'b1 || {s1, s0} !== 2'd2) begin
      fails++;
      $display("[TB] FAIL areset_setup: busy=%b v=%b sel=%0d, required 1010/1/2", busy, out_valid, {s1, s0});
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 4'b0000 || out_valid !== 1'b0 || {s1, s0} !== 2'd0 || out !== 8'h00) begin
      fails++;
      $display("[TB] FAIL areset_immediate: busy=%b v=%b sel=%0d out=%h, required 0000/0/0/00",
               busy, out_valid, {s1, s0}, out);
    end
    tick();
    rst_n = 1'b1;
    in0 = 8'h60; in3 = 8'h63; wr = 4'b1001;
    push(2'd0, 8'h60);
    push(2'd3, 8'h63);
    tick();
    wr = 4'b0000;
    tick();
    tests++;
    if ({s1, s0} !== 2'd0 || out !== 8'h60 || out_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL areset_first_grant: sel=%0d out=%h v=%b, required 0/60/1", {s1, s0}, out, out_valid);
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL areset_drain: %0d words outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_all_four();
    test_rr_wrap();
    test_overflow();
    test_rewrite_during_grant();
    test_async_reset();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
